// File: rtl/cv32e40p_tmr_fault_monitor_if.sv
// Replica-compare bus between a triplicated CSR instance and its fault monitor.
// The master side owns the compare strobe, replica words, clear and ack;
// the slave side (the monitor) returns the voted word and fault status.
interface cv32e40p_tmr_fault_monitor_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             cmp_en_i;
  logic [WIDTH-1:0] res1_i;
  logic [WIDTH-1:0] res2_i;
  logic [WIDTH-1:0] res3_i;
  logic             clear_i;
  logic             resync_ack_i;
  logic [WIDTH-1:0] voted_o;
  logic             mismatch_o;
  logic [1:0]       faulty_replica_o;
  logic             multi_fault_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic             resync_req_o;
  logic             uncorrectable_o;

  modport master (
    output cmp_en_i, res1_i, res2_i, res3_i, clear_i, resync_ack_i,
    input  voted_o, mismatch_o, faulty_replica_o, multi_fault_o,
           err_cnt_o, resync_req_o, uncorrectable_o
  );

  modport slave (
    input  cmp_en_i, res1_i, res2_i, res3_i, clear_i, resync_ack_i,
    output voted_o, mismatch_o, faulty_replica_o, multi_fault_o,
           err_cnt_o, resync_req_o, uncorrectable_o
  );
endinterface

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// TMR fault monitor: registered bitwise majority vote of three replica words,
// per-replica disagreement attribution, persistent-fault streak tracking with
// a resync req/ack handshake, saturating error counter and sticky
// uncorrectable flag.
module cv32e40p_tmr_fault_monitor #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PERSIST_THR = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  cv32e40p_tmr_fault_monitor_if.slave   bus
);

  localparam int unsigned    SW       = $clog2(PERSIST_THR + 1);
  localparam logic [SW-1:0]  THR_LAST = SW'(PERSIST_THR - 1);

  typedef enum logic [1:0] {
    ST_OK,
    ST_SUSPECT,
    ST_FAULT,
    ST_UNCORR
  } state_t;

  state_t           state;
  logic [SW-1:0]    streak;

  logic [WIDTH-1:0] maj;
  logic [2:0]       dis;
  logic             any_dis;
  logic             multi_dis;
  logic [1:0]       dis_code;

  // Majority vote and classification of which replicas disagree with it
  always_comb begin
    maj       = (bus.res1_i & bus.res2_i) | (bus.res1_i & bus.res3_i) |
                (bus.res2_i & bus.res3_i);
    dis       = {bus.res3_i != maj, bus.res2_i != maj, bus.res1_i != maj};
    any_dis   = |dis;
    multi_dis = (dis[0] & dis[1]) | (dis[0] & dis[2]) | (dis[1] & dis[2]);
    dis_code  = 2'd0;
    if (dis[0])      dis_code = 2'd1;
    else if (dis[1]) dis_code = 2'd2;
    else if (dis[2]) dis_code = 2'd3;
  end

  // Fault-tracking FSM with all status outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_OK;
      streak               <= '0;
      bus.voted_o          <= '0;
      bus.mismatch_o       <= 1'b0;
      bus.multi_fault_o    <= 1'b0;
      bus.faulty_replica_o <= 2'd0;
      bus.err_cnt_o        <= '0;
      bus.resync_req_o     <= 1'b0;
      bus.uncorrectable_o  <= 1'b0;
    end else if (bus.clear_i) begin
      // Clear swallows a coincident compare entirely; the voted word is held.
      state                <= ST_OK;
      streak               <= '0;
      bus.mismatch_o       <= 1'b0;
      bus.multi_fault_o    <= 1'b0;
      bus.faulty_replica_o <= 2'd0;
      bus.err_cnt_o        <= '0;
      bus.resync_req_o     <= 1'b0;
      bus.uncorrectable_o  <= 1'b0;
    end else begin
      bus.mismatch_o    <= bus.cmp_en_i & any_dis;
      bus.multi_fault_o <= bus.cmp_en_i & multi_dis;
      if (bus.cmp_en_i) begin
        bus.voted_o <= maj;
        if (any_dis && bus.err_cnt_o != '1)
          bus.err_cnt_o <= bus.err_cnt_o + 1'b1;
      end

      // Ack wins over any coincident compare, including a multi fault; the
      // compare then only contributes to the counter and pulses above.
      if (state == ST_FAULT && bus.resync_ack_i) begin
        state                <= ST_OK;
        streak               <= '0;
        bus.faulty_replica_o <= 2'd0;
        bus.resync_req_o     <= 1'b0;
      end else if (bus.cmp_en_i && multi_dis) begin
        state                <= ST_UNCORR;
        streak               <= '0;
        bus.faulty_replica_o <= 2'd0;
        bus.resync_req_o     <= 1'b0;
        bus.uncorrectable_o  <= 1'b1;
      end else if (bus.cmp_en_i && any_dis) begin
        case (state)
          ST_OK: begin
            bus.faulty_replica_o <= dis_code;
            streak               <= SW'(1);
            if (PERSIST_THR == 1) begin
              state            <= ST_FAULT;
              bus.resync_req_o <= 1'b1;
            end else begin
              state <= ST_SUSPECT;
            end
          end
          ST_SUSPECT: begin
            if (bus.faulty_replica_o == dis_code) begin
              streak <= streak + 1'b1;
              if (streak == THR_LAST) begin
                state            <= ST_FAULT;
                bus.resync_req_o <= 1'b1;
              end
            end else begin
              bus.faulty_replica_o <= dis_code;
              streak               <= SW'(1);
            end
          end
          default: ;
        endcase
      end else if (bus.cmp_en_i && state == ST_SUSPECT) begin
        state                <= ST_OK;
        streak               <= '0;
        bus.faulty_replica_o <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Bench for cv32e40p_tmr_fault_monitor: directed scenarios on a default
// instance (threshold 4, 16-bit counter) and a small instance (threshold 1,
// 2-bit counter), followed by random traffic against a behavioural model.
module tb_cv32e40p_tmr_fault_monitor;

  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cv32e40p_tmr_fault_monitor_if #(.WIDTH(32), .CNT_W(16)) ifa ();
  cv32e40p_tmr_fault_monitor_if #(.WIDTH(32), .CNT_W(2))  ifb ();

  cv32e40p_tmr_fault_monitor #(.WIDTH(32), .PERSIST_THR(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  cv32e40p_tmr_fault_monitor #(.WIDTH(32), .PERSIST_THR(1), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] voted;
    logic        mism;
    logic        multi;
    logic [1:0]  faulty;
    int          cnt;
    logic        req;
    logic        uncorr;
    int          streak;
  } model_t;

  model_t ma;
  model_t mb;

  // Reference: majority by vote counting; "in fault" is simply "request raised".
  function automatic model_t step(model_t m, int thr, int cmax, logic r, logic en,
                                  logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                  logic clr, logic ack);
    logic [31:0] maj;
    int nd, who, v;
    for (int i = 0; i < 32; i++) begin
      v = int'(a[i]) + int'(b[i]) + int'(c[i]);
      maj[i] = (v >= 2);
    end
    nd = 0; who = 0;
    if (c != maj) begin nd++; who = 3; end
    if (b != maj) begin nd++; who = 2; end
    if (a != maj) begin nd++; who = 1; end
    if (r) begin
      m = '{default: 0};
      return m;
    end
    if (clr) begin
      m.mism = 0; m.multi = 0; m.faulty = 0; m.cnt = 0;
      m.req = 0; m.uncorr = 0; m.streak = 0;
      return m;
    end
    m.mism  = en && nd > 0;
    m.multi = en && nd >= 2;
    if (en) begin
      m.voted = maj;
      if (nd > 0 && m.cnt < cmax) m.cnt++;
    end
    if (m.req && ack) begin
      m.req = 0; m.faulty = 0; m.streak = 0;
    end else if (en && nd >= 2) begin
      m.uncorr = 1; m.req = 0; m.faulty = 0; m.streak = 0;
    end else if (en && !m.uncorr && !m.req) begin
      if (nd == 1) begin
        if (int'(m.faulty) == who) m.streak++;
        else begin m.faulty = 2'(who); m.streak = 1; end
        if (m.streak >= thr) m.req = 1;
      end else begin
        m.faulty = 0; m.streak = 0;
      end
    end
    return m;
  endfunction

  // Apply one cycle of inputs to both instances and advance both models
  task automatic cyc(input logic r, input logic en, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c,
                     input logic clr, input logic ack);
    rst = r;
    ifa.cmp_en_i = en; ifa.res1_i = a; ifa.res2_i = b; ifa.res3_i = c;
    ifa.clear_i = clr; ifa.resync_ack_i = ack;
    ifb.cmp_en_i = en; ifb.res1_i = a; ifb.res2_i = b; ifb.res3_i = c;
    ifb.clear_i = clr; ifb.resync_ack_i = ack;
    @(posedge clk);
    #1;
    ma = step(ma, 4, 65535, r, en, a, b, c, clr, ack);
    mb = step(mb, 1, 3, r, en, a, b, c, clr, ack);
  endtask

  task automatic test_reset();
    cyc(1, 0, '0, '0, '0, 0, 0);
    n_cmp++;
    if ({ifa.voted_o, ifa.mismatch_o, ifa.multi_fault_o, ifa.faulty_replica_o,
         ifa.err_cnt_o, ifa.resync_req_o, ifa.uncorrectable_o} !== 54'd0) begin
      n_err++;
      $display("FAIL reset_a: got voted=%h cnt=%0d req=%b unc=%b expected all zero",
               ifa.voted_o, ifa.err_cnt_o, ifa.resync_req_o, ifa.uncorrectable_o);
    end
    n_cmp++;
    if ({ifb.voted_o, ifb.mismatch_o, ifb.multi_fault_o, ifb.faulty_replica_o,
         ifb.err_cnt_o, ifb.resync_req_o, ifb.uncorrectable_o} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_b: got voted=%h cnt=%0d req=%b expected all zero",
               ifb.voted_o, ifb.err_cnt_o, ifb.resync_req_o);
    end
  endtask

  task automatic test_clean();
    cyc(1, 0, '0, '0, '0, 0, 0);
    cyc(0, 1, DB, DB, DB, 0, 0);
    n_cmp++;
    if (ifa.voted_o !== DB || ifa.mismatch_o !== 1'b0 || ifa.err_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL clean: got voted=%h mism=%b cnt=%0d expected %h 0 0",
               ifa.voted_o, ifa.mismatch_o, ifa.err_cnt_o, DB);
    end
    cyc(0, 0, 32'h1234, 32'h5678, 32'h9ABC, 0, 0);
    n_cmp++;
    if (ifa.voted_o !== DB) begin
      n_err++;
      $display("FAIL voted_hold: got %h expected %h", ifa.voted_o, DB);
    end
  endtask

  task automatic test_single_transient();
    cyc(1, 0, '0, '0, '0, 0, 0);
    cyc(0, 1, DB, 32'hDEADBEEE, DB, 0, 0);
    n_cmp++;
    if (ifa.voted_o !== DB || ifa.mismatch_o !== 1'b1 || ifa.faulty_replica_o !== 2'd2 ||
        ifa.err_cnt_o !== 16'd1 || ifa.resync_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL transient: got voted=%h mism=%b fr=%0d cnt=%0d req=%b expected %h 1 2 1 0",
               ifa.voted_o, ifa.mismatch_o, ifa.faulty_replica_o, ifa.err_cnt_o,
               ifa.resync_req_o, DB);
    end
    n_cmp++;
    if (ifb.resync_req_o !== 1'b1 || ifb.faulty_replica_o !== 2'd2) begin
      n_err++;
      $display("FAIL thr1_req: got req=%b fr=%0d expected 1 2",
               ifb.resync_req_o, ifb.faulty_replica_o);
    end
    cyc(0, 1, DB, DB, DB, 0, 0);
    n_cmp++;
    if (ifa.faulty_replica_o !== 2'd0 || ifa.mismatch_o !== 1'b0 || ifa.err_cnt_o !== 16'd1) begin
      n_err++;
      $display("FAIL transient_clear: got fr=%0d mism=%b cnt=%0d expected 0 0 1",
               ifa.faulty_replica_o, ifa.mismatch_o, ifa.err_cnt_o);
    end
    n_cmp++;
    if (ifb.resync_req_o !== 1'b1 || ifb.faulty_replica_o !== 2'd2) begin
      n_err++;
      $display("FAIL thr1_hold: got req=%b fr=%0d expected 1 2",
               ifb.resync_req_o, ifb.faulty_replica_o);
    end
    cyc(0, 0, DB, DB, DB, 0, 1);
    n_cmp++;
    if (ifb.resync_req_o !== 1'b0 || ifb.faulty_replica_o !== 2'd0) begin
      n_err++;
      $display("FAIL thr1_ack: got req=%b fr=%0d expected 0 0",
               ifb.resync_req_o, ifb.faulty_replica_o);
    end
  endtask

  task automatic test_persistent();
    cyc(1, 0, '0, '0, '0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, DB, DB, DB ^ 32'h10, 0, 0);
      n_cmp++;
      if (ifa.resync_req_o !== (i == 4) || ifa.faulty_replica_o !== 2'd3) begin
        n_err++;
        $display("FAIL persist_%0d: got req=%b fr=%0d expected %b 3",
                 i, ifa.resync_req_o, ifa.faulty_replica_o, (i == 4));
      end
    end
    cyc(0, 0, DB, DB, DB, 0, 0);
    n_cmp++;
    if (ifa.resync_req_o !== 1'b1 || ifa.mismatch_o !== 1'b0 || ifa.err_cnt_o !== 16'd4) begin
      n_err++;
      $display("FAIL persist_hold: got req=%b mism=%b cnt=%0d expected 1 0 4",
               ifa.resync_req_o, ifa.mismatch_o, ifa.err_cnt_o);
    end
    cyc(0, 0, DB, DB, DB, 0, 1);
    n_cmp++;
    if (ifa.resync_req_o !== 1'b0 || ifa.faulty_replica_o !== 2'd0 || ifa.err_cnt_o !== 16'd4) begin
      n_err++;
      $display("FAIL persist_ack: got req=%b fr=%0d cnt=%0d expected 0 0 4",
               ifa.resync_req_o, ifa.faulty_replica_o, ifa.err_cnt_o);
    end
  endtask

  task automatic test_streak_reset();
    cyc(1, 0, '0, '0, '0, 0, 0);
    cyc(0, 1, DB ^ 32'h1, DB, DB, 0, 0);
    cyc(0, 1, DB ^ 32'h1, DB, DB, 0, 0);
    cyc(0, 1, DB, DB ^ 32'h8000, DB, 0, 0);
    n_cmp++;
    if (ifa.faulty_replica_o !== 2'd2 || ifa.resync_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL streak_switch: got fr=%0d req=%b expected 2 0",
               ifa.faulty_replica_o, ifa.resync_req_o);
    end
    cyc(0, 1, DB, DB, DB, 0, 0);
    n_cmp++;
    if (ifa.faulty_replica_o !== 2'd0) begin
      n_err++;
      $display("FAIL streak_clean: got fr=%0d expected 0", ifa.faulty_replica_o);
    end
  endtask

  task automatic test_multi();
    cyc(1, 0, '0, '0, '0, 0, 0);
    cyc(0, 1, 32'h1, 32'h2, 32'h0, 0, 0);
    n_cmp++;
    if (ifa.voted_o !== 32'h0 || ifa.multi_fault_o !== 1'b1 || ifa.uncorrectable_o !== 1'b1 ||
        ifa.faulty_replica_o !== 2'd0) begin
      n_err++;
      $display("FAIL multi: got voted=%h mf=%b unc=%b fr=%0d expected 0 1 1 0",
               ifa.voted_o, ifa.multi_fault_o, ifa.uncorrectable_o, ifa.faulty_replica_o);
    end
    cyc(0, 1, DB, DB, DB, 0, 0);
    n_cmp++;
    if (ifa.uncorrectable_o !== 1'b1 || ifa.multi_fault_o !== 1'b0 || ifa.voted_o !== DB) begin
      n_err++;
      $display("FAIL multi_sticky: got unc=%b mf=%b voted=%h expected 1 0 %h",
               ifa.uncorrectable_o, ifa.multi_fault_o, ifa.voted_o, DB);
    end
    cyc(0, 0, DB, DB, DB, 1, 0);
    n_cmp++;
    if (ifa.uncorrectable_o !== 1'b0 || ifa.err_cnt_o !== 16'd0 || ifa.voted_o !== DB) begin
      n_err++;
      $display("FAIL multi_clear: got unc=%b cnt=%0d voted=%h expected 0 0 %h",
               ifa.uncorrectable_o, ifa.err_cnt_o, ifa.voted_o, DB);
    end
  endtask

  task automatic test_saturation();
    cyc(1, 0, '0, '0, '0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, DB ^ 32'h4, DB, DB, 0, 0);
      n_cmp++;
      if (ifb.err_cnt_o !== 2'((i > 3) ? 3 : i)) begin
        n_err++;
        $display("FAIL sat_%0d: got %0d expected %0d", i, ifb.err_cnt_o, (i > 3) ? 3 : i);
      end
    end
    cyc(0, 1, DB ^ 32'h4, DB, DB, 1, 0);
    n_cmp++;
    if (ifb.err_cnt_o !== 2'd0 || ifa.err_cnt_o !== 16'd0 || ifa.mismatch_o !== 1'b0) begin
      n_err++;
      $display("FAIL clear_priority: got cnt_b=%0d cnt_a=%0d mism=%b expected 0 0 0",
               ifb.err_cnt_o, ifa.err_cnt_o, ifa.mismatch_o);
    end
  endtask

  task automatic test_ack_priority();
    cyc(1, 0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, DB, DB ^ 32'h100, DB, 0, 0);
    cyc(0, 1, 32'h1, 32'h2, 32'h0, 0, 1);
    n_cmp++;
    if (ifa.resync_req_o !== 1'b0 || ifa.uncorrectable_o !== 1'b0 ||
        ifa.multi_fault_o !== 1'b1 || ifa.err_cnt_o !== 16'd5) begin
      n_err++;
      $display("FAIL ack_vs_multi: got req=%b unc=%b mf=%b cnt=%0d expected 0 0 1 5",
               ifa.resync_req_o, ifa.uncorrectable_o, ifa.multi_fault_o, ifa.err_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, c, base;
    logic en, clr, ack, r;
    logic [53:0] got_a, exp_a;
    logic [39:0] got_b, exp_b;
    int sel, k, sticky;
    sticky = 0;
    cyc(1, 0, '0, '0, '0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      base = $urandom;
      a = base; b = base; c = base;
      sel = int'($urandom_range(99));
      if (sel >= 45 && sel < 88) begin
        k = ($urandom_range(9) < 8) ? sticky : int'($urandom_range(2));
        case (k)
          0: a = base ^ (32'd1 << $urandom_range(31, 0));
          1: b = base ^ (32'd1 << $urandom_range(31, 0));
          default: c = base ^ (32'd1 << $urandom_range(31, 0));
        endcase
      end else if (sel >= 88) begin
        a = base ^ (32'd1 << $urandom_range(31, 0));
        b = base ^ (32'd1 << $urandom_range(31, 0));
        if ($urandom_range(1) == 0) c = base ^ (32'd1 << $urandom_range(31, 0));
      end
      if ($urandom_range(29) == 0) sticky = int'($urandom_range(2));
      en  = ($urandom_range(9) < 8);
      clr = ($urandom_range(49) == 0);
      r   = ($urandom_range(99) == 0);
      ack = (ma.req || mb.req) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      cyc(r, en, a, b, c, clr, ack);
      got_a = {ifa.voted_o, ifa.mismatch_o, ifa.multi_fault_o, ifa.faulty_replica_o,
               ifa.err_cnt_o, ifa.resync_req_o, ifa.uncorrectable_o};
      exp_a = {ma.voted, ma.mism, ma.multi, ma.faulty, 16'(ma.cnt), ma.req, ma.uncorr};
      n_cmp++;
      if (got_a !== exp_a) begin
        n_err++;
        $display("FAIL random_a cycle %0d: got %h expected %h", n, got_a, exp_a);
      end
      got_b = {ifb.voted_o, ifb.mismatch_o, ifb.multi_fault_o, ifb.faulty_replica_o,
               ifb.err_cnt_o, ifb.resync_req_o, ifb.uncorrectable_o};
      exp_b = {mb.voted, mb.mism, mb.multi, mb.faulty, 2'(mb.cnt), mb.req, mb.uncorr};
      n_cmp++;
      if (got_b !== exp_b) begin
        n_err++;
        $display("FAIL random_b cycle %0d: got %h expected %h", n, got_b, exp_b);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_clean();
    test_single_transient();
    test_persistent();
    test_streak_reset();
    test_multi();
    test_saturation();
    test_ack_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
